cache_2way: RTL and testbench

Parametrised 2-way set-associative, write-back, write-allocate data cache, the successor to the team's direct-mapped cache. It sits between the pipeline's memory stage and the 128-bit block memory, keeps the same processor and memory handshake, and adds configurable set count, pseudo-LRU replacement, and request-qualified miss handling (an idle processor never triggers a refill).

---
 rtl/cache_2way.sv | 169 ++++++++++++++++
 tb/tb_cache_2way.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_2way.sv
// 2-way set-associative write-back / write-allocate data cache with per-set pseudo-LRU.
// Optional hit/miss counters are enabled by defining CACHE_PERF_CNT_EN.
module cache_2way #(
  parameter int unsigned NUM_SETS = 4,
  parameter int unsigned ADDR_W   = 30
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int unsigned IndexW = $clog2(NUM_SETS);
  localparam int unsigned TagW   = ADDR_W - 2 - IndexW;

  typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;

  logic [1:0]          valid_q [NUM_SETS];
  logic [1:0]          dirty_q [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;
  logic [TagW-1:0]     tag_q   [NUM_SETS][2];
  logic [127:0]        data_q  [NUM_SETS][2];

  logic [IndexW-1:0] idx;
  logic [TagW-1:0]   tag;
  logic [6:0]        word_lsb;
  logic [1:0]        match;
  logic              req, hit, hit_way, victim_sel, victim_dirty;
  logic              hit_upd, wb_done, fill;

  assign idx      = proc_addr[IndexW+1:2];
  assign tag      = proc_addr[ADDR_W-1:IndexW+2];
  assign word_lsb = {proc_addr[1:0], 5'b0};
  assign req      = proc_read | proc_write;

  always_comb begin
    for (int unsigned w = 0; w < 2; w++) begin
      match[w] = valid_q[idx][w] && (tag_q[idx][w] == tag);
    end
  end

  assign hit     = req && (|match);
  assign hit_way = match[1];

  // Prefer an empty way (way0 first); fall back to the LRU way when the set is full.
  assign victim_sel   = !valid_q[idx][0] ? 1'b0 :
                        !valid_q[idx][1] ? 1'b1 : lru_q[idx];
  assign victim_dirty = valid_q[idx][victim_sel] && dirty_q[idx][victim_sel];

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    proc_stall = 1'b1;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    hit_upd    = 1'b0;
    wb_done    = 1'b0;
    fill       = 1'b0;
    unique case (state_q)
      StIdle: state_d = StCompare;
      StCompare: begin
        if (!req) begin
          proc_stall = 1'b0;
        end else if (hit) begin
          proc_stall = 1'b0;
          hit_upd    = 1'b1;
          // Read and write together is treated as a write, so no read data then.
          if (!proc_write) proc_rdata = data_q[idx][hit_way][word_lsb +: 32];
        end else begin
          victim_d = victim_sel;
          state_d  = victim_dirty ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[idx][victim_q], idx};
        mem_wdata = data_q[idx][victim_q];
        if (mem_ready) begin
          wb_done = 1'b1;
          state_d = StAllocate;
        end
      end
      StAllocate: begin
        mem_read = 1'b1;
        mem_addr = proc_addr[ADDR_W-1:2];
        if (mem_ready) begin
          fill    = 1'b1;
          state_d = StCompare;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q  <= StIdle;
      victim_q <= 1'b0;
      lru_q    <= '0;
      for (int unsigned s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit_upd) begin
        lru_q[idx] <= ~hit_way;
        if (proc_write) dirty_q[idx][hit_way] <= 1'b1;
      end
      if (wb_done) dirty_q[idx][victim_q] <= 1'b0;
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; the enables above are already gated by the FSM state.
  always_ff @(posedge clk) begin
    if (hit_upd && proc_write) data_q[idx][hit_way][word_lsb +: 32] <= proc_wdata;
    if (fill) begin
      data_q[idx][victim_q] <= mem_rdata;
      tag_q[idx][victim_q]  <= tag;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_upd) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == StCompare && (state_d == StWriteback || state_d == StAllocate)) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_cache_2way.sv
// Scoreboard bench for cache_2way: directed accesses with hand-computed read data and
// memory requests, checked by independent processor-side and memory-side monitors.
module tb_cache_2way;

  logic         clk = 1'b0;
  logic         proc_reset, proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata, proc_rdata;
  logic         proc_stall, mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  always #5 clk = ~clk;

  cache_2way #(.NUM_SETS(4), .ADDR_W(30)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_rdata (proc_rdata),
    .proc_stall (proc_stall),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } mreq_t;

  int           tests = 0;
  int           fails = 0;
  logic [31:0]  sb_q[$];
  mreq_t        mq[$];
  logic [127:0] mem_model [16];
  int           lat = 2;

  localparam logic [127:0] Blk0  = 128'h0000_0A03_0000_0A02_0000_0A01_0000_0A00;
  localparam logic [127:0] Blk4  = 128'h0000_4444_0000_3333_0000_2222_0000_1111;
  localparam logic [127:0] Blk8  = 128'h0000_0C03_0000_0C02_0000_0C01_0000_0C00;
  localparam logic [127:0] BlkC  = 128'h0000_0D03_0000_0D02_0000_0D01_0000_0D00;
  localparam logic [127:0] Blk0W = 128'h0000_0A03_0000_0A02_DEAD_BEEF_0000_0A00;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input bit wr, input logic [27:0] a, input logic [127:0] d);
    mreq_t m;
    m.wr = wr;
    m.addr = a;
    m.wdata = d;
    mq.push_back(m);
  endtask

  // Memory model plus memory-side monitor.
  int    cnt = 0;
  mreq_t cur;
  bit    have_cur = 1'b0;
  always @(negedge clk) begin
    if (mem_ready) mem_ready = 1'b0;
    if (!proc_reset && (mem_read || mem_write)) begin
      cnt++;
      if (cnt == 1) begin
        if (mq.size() == 0) begin
          tests++;
          fails++;
          have_cur = 1'b0;
          $display("FAIL mem_unexpected: got wr=%0b addr=%0h expected no request",
                   mem_write, mem_addr);
        end else begin
          cur = mq.pop_front();
          have_cur = 1'b1;
        end
      end
      chk("mem_one_req", {127'b0, mem_read & mem_write}, '0);
      if (have_cur) begin
        chk("mem_kind", {127'b0, mem_write}, {127'b0, cur.wr});
        chk("mem_addr", {100'b0, mem_addr}, {100'b0, cur.addr});
        if (cur.wr) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      if (cnt >= lat) begin
        if (mem_read) mem_rdata = mem_model[mem_addr[3:0]];
        else mem_model[mem_addr[3:0]] = mem_wdata;
        mem_ready = 1'b1;
        cnt = 0;
      end
    end else begin
      cnt = 0;
    end
  end

  // Processor-side monitor: every completed read pops one expected word.
  always @(negedge clk) begin
    if (!proc_reset && proc_read && !proc_write && !proc_stall) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_unexpected: got %0h expected no read", proc_rdata);
      end else begin
        chk("rdata", {96'b0, proc_rdata}, {96'b0, sb_q.pop_front()});
      end
    end
  end

  task automatic wait_done(input string name, output int stalls);
    stalls = 0;
    forever begin
      @(negedge clk);
      if (!proc_stall) break;
      stalls++;
      if (stalls > 100) begin
        tests++;
        fails++;
        $display("FAIL %s_timeout: got stall after %0d cycles expected release", name, stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic rd(input string name, input logic [29:0] a, input logic [31:0] d,
                    input int exp_stalls);
    int s;
    sb_q.push_back(d);
    proc_addr = a;
    proc_read = 1'b1;
    proc_write = 1'b0;
    wait_done(name, s);
    chk({name, "_stalls"}, 128'(s), 128'(exp_stalls));
  endtask

  task automatic wr(input string name, input logic [29:0] a, input logic [31:0] d,
                    input int exp_stalls);
    int s;
    proc_addr = a;
    proc_wdata = d;
    proc_write = 1'b1;
    proc_read = 1'b0;
    wait_done(name, s);
    chk({name, "_stalls"}, 128'(s), 128'(exp_stalls));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    proc_reset = 1'b1;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    mem_model[0]  = Blk0;
    mem_model[4]  = Blk4;
    mem_model[8]  = Blk8;
    mem_model[12] = BlkC;

    @(negedge clk);
    chk("rst_stall", {127'b0, proc_stall}, 128'd1);
    chk("rst_mem_read", {127'b0, mem_read}, '0);
    chk("rst_mem_write", {127'b0, mem_write}, '0);
    chk("rst_mem_addr", {100'b0, mem_addr}, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_rdata", {96'b0, proc_rdata}, '0);
    @(posedge clk); #1 proc_reset = 1'b0;
    @(posedge clk); #1;

    // No request: cache must stay quiet whatever the address.
    for (int i = 0; i < 20; i++) begin
      proc_addr = 30'($urandom());
      @(negedge clk);
      chk("idle_stall", {127'b0, proc_stall}, '0);
      chk("idle_mem_rw", {126'b0, mem_read, mem_write}, '0);
      chk("idle_rdata", {96'b0, proc_rdata}, '0);
      @(posedge clk); #1;
    end

    exp_mem(0, 28'h4, '0);
    rd("cold_0x10", 30'h10, 32'h0000_1111, 3);
    exp_mem(0, 28'h0, '0);
    rd("fill_0x00", 30'h00, 32'h0000_0A00, 3);
    rd("hit_0x00", 30'h00, 32'h0000_0A00, 0);
    exp_mem(0, 28'h8, '0);
    rd("lru_0x20", 30'h20, 32'h0000_0C00, 3);
    rd("hit2_0x00", 30'h00, 32'h0000_0A00, 0);
    exp_mem(0, 28'h4, '0);
    rd("evicted_0x10", 30'h10, 32'h0000_1111, 3);

    wr("wr_0x01", 30'h01, 32'hDEAD_BEEF, 0);
    rd("hit_0x10", 30'h10, 32'h0000_1111, 0);
    exp_mem(1, 28'h0, Blk0W);
    exp_mem(0, 28'h8, '0);
    rd("dirty_0x20", 30'h20, 32'h0000_0C00, 5);
    exp_mem(0, 28'h0, '0);
    rd("wb_0x01", 30'h01, 32'hDEAD_BEEF, 3);

    // Reset in the middle of a refill.
    lat = 1000;
    exp_mem(0, 28'hC, '0);
    proc_addr = 30'h30;
    proc_read = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!mem_read && w < 10);
    chk("abort_alloc_reached", {127'b0, mem_read}, 128'd1);
    @(posedge clk); #3 proc_reset = 1'b1;
    #1;
    chk("abort_mem_read", {127'b0, mem_read}, '0);
    chk("abort_stall", {127'b0, proc_stall}, 128'd1);
    chk("abort_mem_addr", {100'b0, mem_addr}, '0);
    @(posedge clk); #1;
    proc_read  = 1'b0;
    proc_reset = 1'b0;
    lat = 2;
    @(posedge clk); #1;
    exp_mem(0, 28'hC, '0);
    rd("after_rst_0x30", 30'h30, 32'h0000_0D00, 3);

    repeat (3) @(posedge clk);
    chk("sb_drained", 128'(sb_q.size()), '0);
    chk("mem_drained", 128'(mq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
